prog_divider: RTL and testbench

Programmable single-clock frequency divider for the synthesizer tone path, the parametrised successor of the fixed divide-by-9 stage. It produces a square wave `oclk` at f_clk/N, with N loadable at runtime. It also produces a one-cycle `tick` strobe at the start of every period. Divisor changes and stops take effect only at period boundaries, so note pitch changes are glitch-free. It sits between the key/note decoder, which supplies N, and the waveform/audio output stage.

---
 rtl/synth_div_pkg.sv | 13 +
 rtl/prog_divider.sv | 151 +++++++++++++++
 tb/tb_prog_divider.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_div_pkg.sv
// Shared definitions for the programmable tone-path divider.
// Provides the two-state run/idle enum and the smallest divisor the
// divider can produce a meaningful square wave with.
package synth_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/prog_divider.sv
// Programmable frequency divider producing a square wave at f_clk/N.
//
// Ports:
//   clk       - single clock, all logic on its rising edge
//   rst       - synchronous active-high reset
//   en        - run request (level); stopping happens at the next wrap
//   div_val   - new divisor N
//   div_load  - one-cycle strobe capturing div_val
//   oclk      - divided square wave, straight from a flop
//   tick      - one-cycle pulse in the first cycle of every period
//   active    - high while the divider is running
//   div_err   - one-cycle pulse after a load of N < MIN_DIV was rejected
//
// Divisor changes and stops are only taken at the period wrap so that
// pitch changes never produce a runt or stretched half-cycle.
module prog_divider
    import synth_div_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             oclk,
    output logic             tick,
    output logic             active,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_HALF = WIDTH'((RESET_DIV + 1) / 2);

    // (n+1)>>1 computed one bit wider so n = 2^WIDTH-1 does not overflow.
    function automatic logic [WIDTH-1:0] half_of(input logic [WIDTH-1:0] n);
        logic [WIDTH:0] sum;
        sum = {1'b0, n} + (WIDTH+1)'(1);
        return sum[WIDTH:1];
    endfunction

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             oclk_q, oclk_d;
    logic             tick_q, tick_d;
    logic             active_q, active_d;
    logic             div_err_q, div_err_d;

    logic load_ok;
    logic load_bad;
    logic wrap;

    assign load_ok  = div_load && (div_val >= WIDTH'(MIN_DIV));
    assign load_bad = div_load && !load_ok;
    assign wrap     = (cnt_q == cur_div_q - WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        half_d     = half_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        div_err_d  = load_bad;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Nothing is running, so a new divisor (or one left queued
                // from a load in the final wrap) can be taken immediately.
                if (load_ok) begin
                    cur_div_d  = div_val;
                    half_d     = half_of(div_val);
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    cur_div_d  = pend_div_q;
                    half_d     = half_of(pend_div_q);
                    pend_vld_d = 1'b0;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        cur_div_d  = pend_div_q;
                        half_d     = half_of(pend_div_q);
                        pend_vld_d = 1'b0;
                    end
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                // Placed after the wrap handling: a load in the wrap cycle
                // re-arms the queue for the following wrap instead.
                if (load_ok) begin
                    pend_div_d = div_val;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from next-state values so they come out of
        // flops yet stay aligned with the registered counter.
        active_d = (state_d == RUN);
        oclk_d   = active_d && (cnt_d < half_d);
        tick_d   = active_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_div_q  <= RST_DIV;
            half_q     <= RST_HALF;
            pend_div_q <= RST_DIV;
            pend_vld_q <= 1'b0;
            oclk_q     <= 1'b0;
            tick_q     <= 1'b0;
            active_q   <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            half_q     <= half_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            oclk_q     <= oclk_d;
            tick_q     <= tick_d;
            active_q   <= active_d;
            div_err_q  <= div_err_d;
        end
    end

    assign oclk    = oclk_q;
    assign tick    = tick_q;
    assign active  = active_q;
    assign div_err = div_err_q;

endmodule

// File: tb/tb_prog_divider.sv
// Self-checking bench for prog_divider: a table of reset/start vectors,
// hand-written sequences for the period-boundary corner cases, then a
// randomized run compared cycle by cycle against a behavioural model.
module tb_prog_divider;

    localparam int W         = 16;
    localparam int RESET_DIV = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         oclk, tick, active, div_err;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: running flag, position inside the period, the
    // divisor in use and a queued divisor (-1 when nothing is queued).
    bit m_run;
    int m_pos;
    int m_n;
    int m_pend;
    bit m_err;

    typedef struct {
        bit rst;
        bit en;
        bit load;
        int val;
        bit oclk;
        bit tick;
        bit active;
        bit err;
    } vec_t;

    vec_t vecs[13];

    prog_divider #(.WIDTH(W), .RESET_DIV(RESET_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .oclk     (oclk),
        .tick     (tick),
        .active   (active),
        .div_err  (div_err)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge with the inputs sampled there.
    task automatic modelStep(input bit r, input bit e, input bit l, input int v);
        bit good;
        int nxt_pend;
        good = l && (v >= 2);
        if (r) begin
            m_run = 0; m_pos = 0; m_n = RESET_DIV; m_pend = -1; m_err = 0;
        end else begin
            m_err = l && !good;
            if (!m_run) begin
                if (good) begin
                    m_n = v; m_pend = -1;
                end else if (m_pend >= 0) begin
                    m_n = m_pend; m_pend = -1;
                end
                m_pos = 0;
                if (e) m_run = 1;
            end else begin
                nxt_pend = m_pend;
                if (m_pos == m_n - 1) begin
                    m_pos = 0;
                    if (m_pend >= 0) begin
                        m_n = m_pend;
                        nxt_pend = -1;
                    end
                    if (!e) m_run = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
                if (good) nxt_pend = v;
                m_pend = nxt_pend;
            end
        end
    endtask

    // Drive one cycle of inputs, step the model on the edge, then sample.
    task automatic applyStimulus(input bit r, input bit e, input bit l, input int v);
        rst      = r;
        en       = e;
        div_load = l;
        div_val  = v[W-1:0];
        @(posedge clk);
        modelStep(r, e, l, v);
        #1;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        bit exp_oclk;
        exp_oclk = m_run && (m_pos < (m_n + 1) / 2);
        checkBit({tag, ".oclk"},    oclk,    exp_oclk);
        checkBit({tag, ".tick"},    tick,    m_run && (m_pos == 0));
        checkBit({tag, ".active"},  active,  m_run);
        checkBit({tag, ".div_err"}, div_err, m_err);
    endtask

    // Run with the given en until the next tick; returns cycles used.
    task automatic runUntilTick(input string tag, input bit e, output int cycles);
        cycles = 0;
        do begin
            applyStimulus(0, e, 0, 0);
            checkOutput(tag);
            cycles++;
        end while (!tick && cycles < 100);
    endtask

    initial begin
        int c;

        // Reset, start at the default N=9 (5 high / 4 low), then a bad load.
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 1, 1, 1, 0};
        vecs[2]  = '{0, 1, 0, 0, 1, 0, 1, 0};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 0};
        vecs[4]  = '{0, 1, 0, 0, 1, 0, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 1, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        vecs[10] = '{0, 1, 0, 0, 1, 1, 1, 0};
        vecs[11] = '{0, 1, 1, 0, 1, 0, 1, 1};
        vecs[12] = '{0, 1, 0, 0, 1, 0, 1, 0};

        $display("[TB] start");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].val);
            checkBit($sformatf("vec%0d.oclk", i),    oclk,    vecs[i].oclk);
            checkBit($sformatf("vec%0d.tick", i),    tick,    vecs[i].tick);
            checkBit($sformatf("vec%0d.active", i),  active,  vecs[i].active);
            checkBit($sformatf("vec%0d.div_err", i), div_err, vecs[i].err);
        end

        // Load N=4 mid-period (now at cnt=2): old period finishes first.
        applyStimulus(0, 1, 1, 4);
        checkOutput("load4");
        runUntilTick("tail9", 1, c);
        checkInt("tail_of_n9", c, 6);
        runUntilTick("n4a", 1, c);
        checkInt("period_n4_first", c, 4);
        runUntilTick("n4b", 1, c);
        checkInt("period_n4_second", c, 4);

        // Loads 6 and 10 before the wrap, 3 in the wrap cycle itself.
        applyStimulus(0, 1, 1, 6);
        checkOutput("load6");
        applyStimulus(0, 1, 1, 10);
        checkOutput("load10");
        applyStimulus(0, 1, 0, 0);
        checkOutput("prewrap");
        applyStimulus(0, 1, 1, 3);
        checkOutput("wrapload3");
        checkBit("wrap_tick", tick, 1'b1);
        runUntilTick("n10", 1, c);
        checkInt("period_last_load_wins", c, 10);
        runUntilTick("n3", 1, c);
        checkInt("period_wrap_load_deferred", c, 3);

        // Rejected loads of 0 and 1 leave the period alone.
        applyStimulus(0, 1, 1, 0);
        checkOutput("bad0");
        checkBit("div_err_val0", div_err, 1'b1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("bad1");
        checkBit("div_err_val1", div_err, 1'b1);
        runUntilTick("afterbad", 1, c);
        checkInt("tail_after_bad", c, 1);
        runUntilTick("n3c", 1, c);
        checkInt("period_unchanged", c, 3);

        // N=8, drop en at cnt=2: five more cycles then idle.
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst2");
        applyStimulus(0, 0, 1, 8);
        checkOutput("idleload8");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("run8");
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("draining");
            checkBit("still_active", active, 1'b1);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("stopped");
        checkBit("stopped_active", active, 1'b0);
        checkBit("stopped_oclk", oclk, 1'b0);

        // Drop en at cnt=2, reassert at cnt=5: no gap.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("rerun8");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("dip");
        end
        runUntilTick("resume", 1, c);
        checkInt("resume_no_gap", c, 3);
        checkBit("resume_active", active, 1'b1);

        // Reset at cnt=3 with a pending load (and a load in the reset cycle).
        applyStimulus(0, 1, 1, 5);
        checkOutput("pend5");
        applyStimulus(0, 1, 0, 0);
        checkOutput("cnt2");
        applyStimulus(0, 1, 0, 0);
        checkOutput("cnt3");
        applyStimulus(1, 1, 1, 6);
        checkOutput("rst_mid");
        checkBit("rst_oclk", oclk, 1'b0);
        checkBit("rst_tick", tick, 1'b0);
        checkBit("rst_active", active, 1'b0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("restart");
        runUntilTick("after_rst", 1, c);
        checkInt("period_after_rst", c, 9);
        runUntilTick("after_rst2", 1, c);
        checkInt("period_after_rst2", c, 9);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, l;
            int v;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 7) == 0);
            v = (l && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1))
                                                 : int'($urandom_range(2, 12));
            applyStimulus(r, e, l, v);
            checkOutput("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
